// File: rtl/udma_arb_pkg.sv
// Shared helpers for the uDMA L2 round-robin arbiter.
// The requester search handles up to MAX_REQ requesters. Callers zero-extend
// narrower request vectors and pointers to that width.
package udma_arb_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  // First set bit of elig at or after ptr, searching upward and wrapping at n_req.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  elig,
                                                   input logic [MAX_ID_W-1:0] ptr,
                                                   input int unsigned         n_req);
    logic [MAX_ID_W-1:0] win;
    logic [MAX_ID_W-1:0] idx4;
    logic                found;
    int unsigned         idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n_req) begin
        idx  = (32'(ptr) + i) % n_req;
        idx4 = idx[MAX_ID_W-1:0];
        if (!found && elig[idx4]) begin
          win   = idx4;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/udma_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions in flight.
// Each pointer carries one extra wrap bit, so full and empty can be told apart.
module udma_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // ID storage; entries are only meaningful between the two pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/udma_l2_rr_arbiter.sv
// Round-robin arbiter sharing one uDMA L2 TCDM master port among N_REQ requesters.
// Responses are routed back in issue order through an ID FIFO.
// Optional: define UDMA_ARB_PRIO_EN to add prio_i. Eligible high-priority
// requesters then win over low-priority ones, and both classes share rr_q.
module udma_l2_rr_arbiter
  import udma_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                  sys_clk_i,
  input  logic                                  sys_rst_i,
  input  logic [N_REQ-1:0]                      req_i,
`ifdef UDMA_ARB_PRIO_EN
  input  logic [N_REQ-1:0]                      prio_i,
`endif
  input  logic [N_REQ-1:0]                      wen_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
  output logic [N_REQ-1:0]                      gnt_o,
  output logic [N_REQ-1:0]                      rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  L2_req_o,
  output logic                                  L2_wen_o,
  output logic [ADDR_WIDTH-1:0]                 L2_addr_o,
  output logic [DATA_WIDTH-1:0]                 L2_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               L2_be_o,
  input  logic                                  L2_gnt_i,
  input  logic                                  L2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 L2_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } l2_req_t;

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [N_REQ-1:0] elig, cand;
  logic             any_req, hs, pop;
  logic             err_q;
  l2_req_t          sel;

  // Eligibility and winner search; full is registered so a pop never un-gates req combinationally.
  always_comb begin
    elig = (sys_rst_i || fifo_full) ? '0 : req_i;
`ifdef UDMA_ARB_PRIO_EN
    cand = (|(elig & prio_i)) ? (elig & prio_i) : elig;
`else
    cand = elig;
`endif
    any_req = |cand;
    win_idx = ID_W'(rr_pick(MAX_REQ'(cand), MAX_ID_W'(rr_q), N_REQ));
  end

  // Forward the winner's fields, zero when idle, and route grant and response one-hots.
  always_comb begin
    sel      = '0;
    gnt_o    = '0;
    rvalid_o = '0;
    if (any_req) begin
      sel.wen   = wen_i[win_idx];
      sel.addr  = addr_i[win_idx];
      sel.wdata = wdata_i[win_idx];
      sel.be    = be_i[win_idx];
    end
    hs  = any_req && L2_gnt_i;
    pop = L2_rvalid_i && !fifo_empty && !sys_rst_i;
    if (hs)  gnt_o[win_idx]      = 1'b1;
    if (pop) rvalid_o[fifo_head] = 1'b1;
    rr_d = rr_q;
    if (hs) rr_d = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
  end

  assign L2_req_o      = any_req;
  assign L2_wen_o      = sel.wen;
  assign L2_addr_o     = sel.addr;
  assign L2_wdata_o    = sel.wdata;
  assign L2_be_o       = sel.be;
  assign rdata_o       = sys_rst_i ? '0 : L2_rdata_i;
  assign outstanding_o = fifo_count;
  assign err_o         = err_q;

  // Round-robin pointer and the sticky flag for a response that has no transaction in flight.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (L2_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  udma_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .push_i  (hs),
    .din_i   (win_idx),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_udma_l2_rr_arbiter.sv
// Bench for udma_l2_rr_arbiter: a table of per-cycle vectors plus reset and priority sequences.
// A queue holds the expected requester ID for each issued transaction and predicts rvalid_o routing.
module tb_udma_l2_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_i;
`ifdef UDMA_ARB_PRIO_EN
  logic [N-1:0]          prio_i;
`endif
  logic [N-1:0]          wen_i;
  logic [N-1:0][AW-1:0]  addr_i;
  logic [N-1:0][DW-1:0]  wdata_i;
  logic [N-1:0][BW-1:0]  be_i;
  logic [N-1:0]          gnt_o, rvalid_o;
  logic [DW-1:0]         rdata_o;
  logic                  L2_req_o, L2_wen_o;
  logic [AW-1:0]         L2_addr_o;
  logic [DW-1:0]         L2_wdata_o;
  logic [BW-1:0]         L2_be_o;
  logic                  L2_gnt_i, L2_rvalid_i;
  logic [DW-1:0]         L2_rdata_i;
  logic [CW-1:0]         outstanding_o;
  logic                  err_o;

  udma_l2_rr_arbiter #(
    .N_REQ           (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) u_dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .req_i         (req_i),
`ifdef UDMA_ARB_PRIO_EN
    .prio_i        (prio_i),
`endif
    .wen_i         (wen_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .be_i          (be_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .L2_req_o      (L2_req_o),
    .L2_wen_o      (L2_wen_o),
    .L2_addr_o     (L2_addr_o),
    .L2_wdata_o    (L2_wdata_o),
    .L2_be_o       (L2_be_o),
    .L2_gnt_i      (L2_gnt_i),
    .L2_rvalid_i   (L2_rvalid_i),
    .L2_rdata_i    (L2_rdata_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic         rv;
    int           win;   // expected winner, -1 when L2_req_o must be low
    int           out;   // expected outstanding_o
    logic         err;
  } vec_t;

  vec_t        vecs[$];
  int          id_q[$];
  logic [AW-1:0] a_tab [N];
  logic [DW-1:0] d_tab [N];
  logic [BW-1:0] b_tab [N];
  logic          w_tab [N];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic vec_t mk(input logic [N-1:0] req, input logic gnt, input logic rv,
                              input int win, input int out, input logic err);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.win = win; v.out = out; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict the response routing from the ID queue, and check mid-cycle.
  task automatic step(input vec_t v);
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] rd;
    int            h;
    rd          = $urandom;
    req_i       = v.req;
    L2_gnt_i    = v.gnt;
    L2_rvalid_i = v.rv;
    L2_rdata_i  = rd;
    exp_rv      = '0;
    if (v.rv && id_q.size() > 0) begin
      h = id_q.pop_front();
      exp_rv[h] = 1'b1;
    end
    if (v.win >= 0 && v.gnt) id_q.push_back(v.win);
    #4;
    chk("L2_req", 64'(L2_req_o), 64'(v.win >= 0));
    chk("gnt", 64'(gnt_o), (v.win >= 0 && v.gnt) ? 64'(1) << v.win : 64'(0));
    if (v.win >= 0) begin
      chk("L2_addr",  64'(L2_addr_o),  64'(a_tab[v.win]));
      chk("L2_wdata", 64'(L2_wdata_o), 64'(d_tab[v.win]));
      chk("L2_be",    64'(L2_be_o),    64'(b_tab[v.win]));
      chk("L2_wen",   64'(L2_wen_o),   64'(w_tab[v.win]));
    end else begin
      chk("L2_addr_idle", 64'(L2_addr_o), 64'(0));
    end
    chk("rvalid", 64'(rvalid_o), 64'(exp_rv));
    if (exp_rv != '0) chk("rdata", 64'(rdata_o), 64'(rd));
    chk("outstanding", 64'(outstanding_o), 64'(v.out));
    chk("err", 64'(err_o), 64'(v.err));
    @(posedge clk);
    #1;
  endtask

  // With reset asserted and every input active, all outputs must read zero.
  task automatic chk_reset();
    req_i = '1; L2_gnt_i = 1'b1; L2_rvalid_i = 1'b1; L2_rdata_i = 32'hDEAD_BEEF;
    #4;
    chk("rst_L2_req", 64'(L2_req_o), 64'(0));
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_rdata", 64'(rdata_o), 64'(0));
    chk("rst_L2_addr", 64'(L2_addr_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0; L2_gnt_i = 1'b0; L2_rvalid_i = 1'b0; L2_rdata_i = '0;
`ifdef UDMA_ARB_PRIO_EN
    prio_i = '0;
`endif
    for (int i = 0; i < N; i++) begin
      a_tab[i]   = 32'h1000_0000 + 32'(i * 16);
      d_tab[i]   = 32'hD000_0000 + 32'(i);
      b_tab[i]   = 4'(i + 1);
      w_tab[i]   = i[0];
      addr_i[i]  = a_tab[i];
      wdata_i[i] = d_tab[i];
      be_i[i]    = b_tab[i];
      wen_i[i]   = w_tab[i];
    end

    // req, gnt, rv, winner, outstanding, err
    vecs.push_back(mk(4'b0101, 1, 0,  0, 0, 0));  // 0,2 alternate
    vecs.push_back(mk(4'b0101, 1, 1,  2, 1, 0));  // first response -> 0001
    vecs.push_back(mk(4'b0101, 1, 0,  0, 1, 0));
    vecs.push_back(mk(4'b0101, 1, 1,  2, 2, 0));  // push+pop at count 2
    vecs.push_back(mk(4'b0101, 1, 1,  0, 2, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 2, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, -1, 0, 0));
    vecs.push_back(mk(4'b1111, 1, 0,  1, 0, 0));  // fill to full
    vecs.push_back(mk(4'b1111, 1, 0,  2, 1, 0));
    vecs.push_back(mk(4'b1111, 1, 0,  3, 2, 0));
    vecs.push_back(mk(4'b1111, 1, 0,  0, 3, 0));
    vecs.push_back(mk(4'b1111, 1, 0, -1, 4, 0));  // full: request gated
    vecs.push_back(mk(4'b1111, 1, 1, -1, 4, 0));  // pop does not un-gate this cycle
    vecs.push_back(mk(4'b1111, 1, 0,  1, 3, 0));  // request back one cycle later
    vecs.push_back(mk(4'b1111, 1, 1, -1, 4, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 3, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 2, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, -1, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0010, 0, 0, 1, 0, 0)); // stalled winner 1
    vecs.push_back(mk(4'b0010, 1, 0,  1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 1, -1, 0, 0));  // response with nothing outstanding
    vecs.push_back(mk(4'b0000, 0, 0, -1, 0, 1));  // err sticks
    vecs.push_back(mk(4'b0110, 0, 0,  2, 0, 1));
    vecs.push_back(mk(4'b0010, 1, 0,  1, 0, 1));  // winner 2 dropped its request
    vecs.push_back(mk(4'b0000, 0, 1, -1, 1, 1));
    vecs.push_back(mk(4'b0011, 1, 0,  0, 0, 1));
    vecs.push_back(mk(4'b0011, 1, 0,  1, 1, 1));

    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset with two transactions in flight: IDs are discarded and a late response flags err.
    rst = 1'b1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_q.delete();
    step(mk(4'b0000, 0, 1, -1, 0, 0));
    step(mk(4'b0000, 0, 0, -1, 0, 1));

`ifdef UDMA_ARB_PRIO_EN
    prio_i = 4'b0100;
    step(mk(4'b1111, 1, 0,  2, 0, 1));
    step(mk(4'b1111, 1, 1,  2, 1, 1));
    step(mk(4'b1111, 1, 1,  2, 1, 1));
    step(mk(4'b0000, 0, 1, -1, 1, 1));
    step(mk(4'b0000, 0, 0, -1, 0, 1));
    prio_i = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
